// File: rtl/xlr8_lfsr_multi.sv
// Galois LFSR XB of WIDTH bits (8..32) on the XLR8 DM bus: programmable taps, multi-byte
// seed, coherent multi-byte readout, free-run, step-on-read and counted step bursts.
module xlr8_lfsr_multi #(
  parameter logic [7:0]  CTRL_ADDR    = 8'd0,
  parameter logic [7:0]  STEP_ADDR    = 8'd0,
  parameter logic [7:0]  SEED_ADDR    = 8'd0,
  parameter logic [7:0]  TAPS_ADDR    = 8'd0,
  parameter logic [7:0]  DATA_ADDR    = 8'd0,
  parameter int unsigned WIDTH        = 8,
  parameter logic [31:0] DEFAULT_TAPS = 32'h0000_00B8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clken,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel
);

  localparam int unsigned      NBYTES = WIDTH / 8;
  localparam logic [7:0]       NB8    = 8'(NBYTES);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic {IDLE, STEP} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             free_q, free_d, sor_q, sor_d, done_q, done_d;
  logic [WIDTH-1:0] seed_q, seed_d, taps_q, taps_d, lfsr_q, lfsr_d, shadow_q, shadow_d;

  logic [7:0]       seed_off, taps_off, data_off, rd_data;
  logic             ctrl_hit, step_hit, seed_hit, taps_hit, data_hit, any_hit;
  logic             we, rd_data0, load, advance;
  logic [WIDTH-1:0] shifted, wr_state;

  function automatic logic [7:0] get_byte(input logic [WIDTH-1:0] v, input logic [7:0] off);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < NBYTES; k++)
      if (off == 8'(k)) b = v[8*k +: 8];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] put_byte(input logic [WIDTH-1:0] v, input logic [7:0] off,
                                                input logic [7:0] b);
    logic [WIDTH-1:0] r;
    r = v;
    for (int unsigned k = 0; k < NBYTES; k++)
      if (off == 8'(k)) r[8*k +: 8] = b;
    return r;
  endfunction

  assign seed_off = ramadr - SEED_ADDR;
  assign taps_off = ramadr - TAPS_ADDR;
  assign data_off = ramadr - DATA_ADDR;

  // Overlapping address maps resolve in the fixed order CTRL, STEP, SEED, TAPS, DATA.
  always_comb begin
    ctrl_hit = (ramadr == CTRL_ADDR);
    step_hit = !ctrl_hit && (ramadr == STEP_ADDR);
    seed_hit = !ctrl_hit && !step_hit && (seed_off < NB8);
    taps_hit = !ctrl_hit && !step_hit && !seed_hit && (taps_off < NB8);
    data_hit = !ctrl_hit && !step_hit && !seed_hit && !taps_hit && (data_off < NB8);
    any_hit  = ctrl_hit || step_hit || seed_hit || taps_hit || data_hit;
  end

  always_comb begin
    rd_data = '0;
    if (ctrl_hit)      rd_data = {3'b000, done_q, fsm_q == STEP, 1'b0, sor_q, free_q};
    else if (step_hit) rd_data = cnt_q;
    else if (seed_hit) rd_data = get_byte(seed_q, seed_off);
    else if (taps_hit) rd_data = get_byte(taps_q, taps_off);
    else if (data_hit) rd_data = (data_off == 8'd0) ? lfsr_q[7:0] : get_byte(shadow_q, data_off);
  end

  assign io_out_en = dm_sel && ramre && any_hit;
  assign dbus_out  = io_out_en ? rd_data : '0;

  always_comb begin
    we       = dm_sel && ramwe && clken;
    rd_data0 = dm_sel && ramre && data_hit && (data_off == 8'd0);
    load     = we && ctrl_hit && dbus_in[2];
    shifted  = lfsr_q[0] ? ((lfsr_q >> 1) ^ taps_q) : (lfsr_q >> 1);
    wr_state = put_byte(lfsr_q, data_off, dbus_in);

    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    free_d   = free_q;
    sor_d    = sor_q;
    done_d   = done_q;
    seed_d   = seed_q;
    taps_d   = taps_q;
    lfsr_d   = lfsr_q;
    shadow_d = shadow_q;

    if (we && ctrl_hit) begin
      free_d = dbus_in[0];
      sor_d  = dbus_in[1];
      if (dbus_in[4]) done_d = 1'b0;
    end
    if (we && seed_hit) seed_d = put_byte(seed_q, seed_off, dbus_in);
    if (we && taps_hit) taps_d = put_byte(taps_q, taps_off, dbus_in);
    if (clken && rd_data0) shadow_d = lfsr_q;

    unique case (fsm_q)
      IDLE: if (we && step_hit && dbus_in != 8'd0) begin
        fsm_d = STEP;
        cnt_d = dbus_in;
      end
      STEP: if (load) begin
        fsm_d = IDLE;
        cnt_d = '0;
      end else if (clken) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end
    endcase

    advance = clken && ((fsm_q == STEP) || free_q || (sor_q && rd_data0));

    // LOAD beats a direct DATA write, which beats an advance; zero always recovers to 1.
    if (load)                lfsr_d = (seed_q == '0) ? ONE : seed_q;
    else if (we && data_hit) lfsr_d = (wr_state == '0) ? ONE : wr_state;
    else if (advance)        lfsr_d = (shifted == '0) ? ONE : shifted;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q    <= IDLE;
      cnt_q    <= '0;
      free_q   <= 1'b0;
      sor_q    <= 1'b0;
      done_q   <= 1'b0;
      seed_q   <= '0;
      taps_q   <= DEFAULT_TAPS[WIDTH-1:0];
      lfsr_q   <= ONE;
      shadow_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      free_q   <= free_d;
      sor_q    <= sor_d;
      done_q   <= done_d;
      seed_q   <= seed_d;
      taps_q   <= taps_d;
      lfsr_q   <= lfsr_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_xlr8_lfsr_multi.sv
// Bench for xlr8_lfsr_multi: an 8-bit instance at 0x10.. and a 16-bit instance at 0x40..
// share the DM bus; reads go through an expected-value queue.
module tb_xlr8_lfsr_multi;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clken = 1'b1;
  logic [7:0] dbus_in = '0;
  logic [7:0] ramadr = '0;
  logic       ramre = 1'b0, ramwe = 1'b0, dm_sel = 1'b0;
  logic [7:0] dout8, dout16;
  logic       en8, en16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xlr8_lfsr_multi #(
    .CTRL_ADDR(8'h10), .STEP_ADDR(8'h11), .SEED_ADDR(8'h12), .TAPS_ADDR(8'h14),
    .DATA_ADDR(8'h18), .WIDTH(8), .DEFAULT_TAPS(32'h0000_00B8)
  ) dut8 (
    .clk(clk), .rstn(rstn), .clken(clken), .dbus_in(dbus_in), .dbus_out(dout8),
    .io_out_en(en8), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel)
  );

  xlr8_lfsr_multi #(
    .CTRL_ADDR(8'h40), .STEP_ADDR(8'h41), .SEED_ADDR(8'h42), .TAPS_ADDR(8'h44),
    .DATA_ADDR(8'h48), .WIDTH(16), .DEFAULT_TAPS(32'h0000_B400)
  ) dut16 (
    .clk(clk), .rstn(rstn), .clken(clken), .dbus_in(dbus_in), .dbus_out(dout16),
    .io_out_en(en16), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       en;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       en;
  } vec_t;

  function automatic logic [31:0] model_next(input logic [31:0] s, input logic [31:0] taps,
                                             input int w);
    logic [31:0] mask, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = s >> 1;
    if (s[0]) r = r ^ taps;
    r = r & mask;
    if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ramadr = a; dbus_in = d; dm_sel = 1'b1; ramwe = 1'b1; ramre = 1'b0;
    @(posedge clk); #1;
    ramwe = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic e);
    @(negedge clk);
    ramadr = a; dm_sel = 1'b1; ramre = 1'b1; ramwe = 1'b0;
    #1;
    d = (a >= 8'h40) ? dout16 : dout8;
    e = (a >= 8'h40) ? en16 : en8;
    @(posedge clk); #1;
    ramre = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] a, input logic [7:0] ed,
                     input logic ee, output logic [7:0] act);
    exp_t x, y;
    logic [7:0] d;
    logic e;
    x.name = name; x.data = ed; x.en = ee;
    exp_q.push_back(x);
    rd(a, d, e);
    y = exp_q.pop_front();
    checks++;
    if (d !== y.data || e !== y.en) begin
      errors++;
      $display("FAIL %s: got data=%02h en=%0b, want data=%02h en=%0b", y.name, d, e, y.data, y.en);
    end
    act = d;
  endtask

  task automatic count_busy(input string name, input logic [7:0] ctrl_a, input int want);
    logic [7:0] d;
    logic e;
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      rd(ctrl_a, d, e);
      if (d[3]) n++;
      else break;
    end
    check(name, n, want);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        rtbl[12];
    logic [7:0]  act, first, b0a, b0b, b1;
    logic [31:0] m, m16, cap;
    logic        seen[256];
    int          dup;

    rtbl[0]  = '{8'h18, 8'h01, 1'b1};
    rtbl[1]  = '{8'h10, 8'h00, 1'b1};
    rtbl[2]  = '{8'h14, 8'hB8, 1'b1};
    rtbl[3]  = '{8'h11, 8'h00, 1'b1};
    rtbl[4]  = '{8'h12, 8'h00, 1'b1};
    rtbl[5]  = '{8'h19, 8'h00, 1'b0};
    rtbl[6]  = '{8'h30, 8'h00, 1'b0};
    rtbl[7]  = '{8'h48, 8'h01, 1'b1};
    rtbl[8]  = '{8'h49, 8'h00, 1'b1};
    rtbl[9]  = '{8'h45, 8'hB4, 1'b1};
    rtbl[10] = '{8'h44, 8'h00, 1'b1};
    rtbl[11] = '{8'h4A, 8'h00, 1'b0};

    // Reset and no-strobe outputs
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_nostrobe", int'(dout8), 0);
    check("rst_en_nostrobe", int'(en8), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++)
      chk($sformatf("reset_%02h", rtbl[i].addr), rtbl[i].addr, rtbl[i].data, rtbl[i].en, act);
    @(negedge clk);
    ramadr = 8'h18; dm_sel = 1'b1; ramre = 1'b0;
    #1;
    check("en_without_ramre", int'(en8), 0);
    dm_sel = 1'b0; ramre = 1'b1;
    #1;
    check("en_without_dm_sel", int'(en8), 0);
    ramre = 1'b0;

    // Counted burst of 4 from state 01
    wr(8'h11, 8'd4);
    count_busy("busy_cycles_4", 8'h10, 4);
    chk("burst4_data", 8'h18, 8'h17, 1'b1, act);
    chk("burst4_done", 8'h10, 8'h10, 1'b1, act);
    wr(8'h10, 8'h00);
    chk("done_kept_on_write0", 8'h10, 8'h10, 1'b1, act);
    wr(8'h10, 8'h10);
    chk("done_cleared", 8'h10, 8'h00, 1'b1, act);

    // LOAD and burst abort
    wr(8'h12, 8'h00);
    wr(8'h10, 8'h04);
    chk("load_zero_seed", 8'h18, 8'h01, 1'b1, act);
    chk("load_reads_0", 8'h10, 8'h00, 1'b1, act);
    wr(8'h12, 8'hA5);
    wr(8'h10, 8'h04);
    chk("load_a5", 8'h18, 8'hA5, 1'b1, act);
    wr(8'h11, 8'd200);
    chk("step_remaining", 8'h11, 8'd200, 1'b1, act);
    wr(8'h11, 8'd5);
    chk("step_write_ignored", 8'h11, 8'd198, 1'b1, act);
    wr(8'h10, 8'h04);
    chk("abort_data", 8'h18, 8'hA5, 1'b1, act);
    chk("abort_ctrl", 8'h10, 8'h00, 1'b1, act);
    chk("abort_step", 8'h11, 8'h00, 1'b1, act);
    wr(8'h11, 8'd0);
    chk("step0_ignored", 8'h10, 8'h00, 1'b1, act);

    // Step-on-read: full period with taps B8
    wr(8'h10, 8'h02);
    m = 32'hA5;
    dup = 0;
    first = '0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("sor_read_%0d", i), 8'h18, m[7:0], 1'b1, act);
      m = model_next(m, 32'hB8, 8);
      if (i == 0) first = act;
      if (i < 255) begin
        if (act == 8'h00 || seen[act]) dup++;
        seen[act] = 1'b1;
      end
    end
    check("sor_distinct", dup, 0);
    check("sor_wrap", int'(act), int'(first));

    // Zero taps: lock-up recovery keeps state nonzero
    wr(8'h14, 8'h00);
    dup = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("taps0_read_%0d", i), 8'h18, m[7:0], 1'b1, act);
      m = model_next(m, 32'h0, 8);
      if (act == 8'h00) dup++;
    end
    check("taps0_nonzero", dup, 0);
    wr(8'h14, 8'hB8);
    wr(8'h10, 8'h00);

    // Direct DATA writes
    wr(8'h18, 8'h00);
    chk("data_write_zero", 8'h18, 8'h01, 1'b1, act);
    wr(8'h18, 8'h3C);
    chk("data_write_3c", 8'h18, 8'h3C, 1'b1, act);

    // clken=0 freezes a burst and drops writes
    wr(8'h18, 8'h01);
    wr(8'h11, 8'd10);
    clken = 1'b0;
    idle(3);
    wr(8'h18, 8'h55);
    wr(8'h10, 8'h04);
    wr(8'h11, 8'd3);
    chk("frozen_step", 8'h11, 8'd10, 1'b1, act);
    chk("frozen_data", 8'h18, 8'h01, 1'b1, act);
    chk("frozen_busy", 8'h10, 8'h08, 1'b1, act);
    clken = 1'b1;
    count_busy("busy_cycles_10", 8'h10, 10);
    m = 32'h01;
    for (int i = 0; i < 10; i++) m = model_next(m, 32'hB8, 8);
    chk("resume_data", 8'h18, m[7:0], 1'b1, act);
    chk("resume_done", 8'h10, 8'h10, 1'b1, act);
    wr(8'h10, 8'h10);
    wr(8'h10, 8'h01);
    clken = 1'b0;
    chk("free_frozen_a", 8'h18, m[7:0], 1'b1, act);
    chk("free_frozen_b", 8'h18, m[7:0], 1'b1, act);
    clken = 1'b1;
    chk("free_resume_a", 8'h18, m[7:0], 1'b1, act);
    m = model_next(m, 32'hB8, 8);
    chk("free_resume_b", 8'h18, m[7:0], 1'b1, act);
    m = model_next(m, 32'hB8, 8);
    wr(8'h10, 8'h00);
    m = model_next(m, 32'hB8, 8);
    chk("free_stopped", 8'h18, m[7:0], 1'b1, act);

    // 16-bit coherent readout under free-run
    wr(8'h44, 8'h00);
    wr(8'h45, 8'hB4);
    wr(8'h40, 8'h01);
    m16 = 32'h1;
    idle(20);
    for (int i = 0; i < 20; i++) m16 = model_next(m16, 32'hB400, 16);
    chk("w16_byte0", 8'h48, m16[7:0], 1'b1, b0a);
    cap = m16;
    m16 = model_next(m16, 32'hB400, 16);
    chk("w16_byte1", 8'h49, cap[15:8], 1'b1, b1);
    m16 = model_next(m16, 32'hB400, 16);
    check("w16_pair", int'({b1, b0a}), int'(cap[15:0]));
    chk("w16_next_byte0", 8'h48, m16[7:0], 1'b1, b0b);
    check("w16_byte0_differs", int'(b0a != b0b), 1);
    wr(8'h42, 8'h34);
    wr(8'h43, 8'h12);
    wr(8'h40, 8'h04);
    chk("w16_load_lo", 8'h48, 8'h34, 1'b1, act);
    chk("w16_load_hi", 8'h49, 8'h12, 1'b1, act);

    // Reset in the middle of a burst
    wr(8'h11, 8'd50);
    idle(3);
    @(negedge clk);
    rstn = 1'b0;
    ramadr = 8'h11; dm_sel = 1'b1; ramre = 1'b1;
    #1;
    check("midrst_step_async", int'(dout8), 0);
    ramre = 1'b0; dm_sel = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_ctrl", 8'h10, 8'h00, 1'b1, act);
    chk("midrst_step", 8'h11, 8'h00, 1'b1, act);
    chk("midrst_data", 8'h18, 8'h01, 1'b1, act);
    chk("midrst_taps", 8'h14, 8'hB8, 1'b1, act);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
